hwpe_stream_demux_burst: RTL and testbench

HWPE_STREAM_DEMUX_BURST -- requirements
Module: hwpe_stream_demux_burst

---
 rtl/hwpe_stream_demux_burst_if.sv | 15 +
 rtl/hwpe_stream_demux_burst.sv | 116 +++++++++++
 tb/tb_hwpe_stream_demux_burst.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hwpe_stream_demux_burst_if.sv
// Valid/ready stream bundle with data and byte strobes.
// The sink modport faces a producer; the source modport faces a consumer.
interface hwpe_stream_intf_stream #(
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [STRB_WIDTH-1:0] strb;

   modport source (output valid, data, strb, input ready);
   modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_demux_burst.sv
// 1-to-2 stream demultiplexer with registered outputs; destination is either
// a static select or alternates every BURST_LEN accepted beats.
module hwpe_stream_demux_burst #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned BURST_LEN  = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   mode_i,
   input  logic                   sel_i,
   hwpe_stream_intf_stream.sink   push_i,
   hwpe_stream_intf_stream.source pop_0_o,
   hwpe_stream_intf_stream.source pop_1_o,
   output logic                   cur_sel_o
);

   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
   localparam int unsigned CNT_W      = $clog2(BURST_LEN) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   logic                  valid0_q, valid0_d;
   logic                  valid1_q, valid1_d;
   logic [DATA_WIDTH-1:0] data0_q, data0_d;
   logic [DATA_WIDTH-1:0] data1_q, data1_d;
   logic [STRB_WIDTH-1:0] strb0_q, strb0_d;
   logic [STRB_WIDTH-1:0] strb1_q, strb1_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  burst_sel_q, burst_sel_d;

   logic dest;
   logic accept;
   logic push_hs;

   // Reset only masks the visible ready; the flops are held by the async reset.
   always_comb begin
      dest    = mode_i ? burst_sel_q : sel_i;
      accept  = !clear_i && (dest ? (!valid1_q || pop_1_o.ready)
                                  : (!valid0_q || pop_0_o.ready));
      push_hs = push_i.valid && accept;
   end

   always_comb begin
      valid0_d    = valid0_q;
      valid1_d    = valid1_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      strb0_d     = strb0_q;
      strb1_d     = strb1_q;
      cnt_d       = cnt_q;
      burst_sel_d = burst_sel_q;

      if (pop_0_o.ready) valid0_d = 1'b0;
      if (pop_1_o.ready) valid1_d = 1'b0;

      if (push_hs && !dest) begin
         valid0_d = 1'b1;
         data0_d  = push_i.data;
         strb0_d  = push_i.strb;
      end
      if (push_hs && dest) begin
         valid1_d = 1'b1;
         data1_d  = push_i.data;
         strb1_d  = push_i.strb;
      end

      if (push_hs && mode_i) begin
         if (cnt_q == CNT_LAST) begin
            cnt_d       = '0;
            burst_sel_d = !burst_sel_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (clear_i) begin
         valid0_d    = 1'b0;
         valid1_d    = 1'b0;
         cnt_d       = '0;
         burst_sel_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         data0_q     <= '0;
         data1_q     <= '0;
         strb0_q     <= '0;
         strb1_q     <= '0;
         cnt_q       <= '0;
         burst_sel_q <= 1'b0;
      end else begin
         valid0_q    <= valid0_d;
         valid1_q    <= valid1_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         strb0_q     <= strb0_d;
         strb1_q     <= strb1_d;
         cnt_q       <= cnt_d;
         burst_sel_q <= burst_sel_d;
      end
   end

   assign push_i.ready  = accept && !rst_i;
   assign cur_sel_o     = dest;

   assign pop_0_o.valid = valid0_q;
   assign pop_0_o.data  = data0_q;
   assign pop_0_o.strb  = strb0_q;
   assign pop_1_o.valid = valid1_q;
   assign pop_1_o.data  = data1_q;
   assign pop_1_o.strb  = strb1_q;

endmodule

// File: tb/tb_hwpe_stream_demux_burst.sv
// Bench for hwpe_stream_demux_burst: directed vector table, hand-written
// clear/reset sequences, and a randomized run against a queue-based model.
module tb_hwpe_stream_demux_burst;

   localparam int unsigned DW = 32;
   localparam int unsigned BL = 4;

   logic clk = 1'b0;
   logic rst, clear, mode, sel;
   logic cur_sel;

   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) push ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop0 ();
   hwpe_stream_intf_stream #(.DATA_WIDTH(DW)) pop1 ();

   hwpe_stream_demux_burst #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .clear_i  (clear),
      .mode_i   (mode),
      .sel_i    (sel),
      .push_i   (push),
      .pop_0_o  (pop0),
      .pop_1_o  (pop1),
      .cur_sel_o(cur_sel)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       m, s, pv;
      logic [7:0] d;
      logic       r0, r1;
      logic       e_rdy, e_cs, e_v0;
      logic [7:0] e_d0;
      logic       e_v1;
      logic [7:0] e_d1;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mkv(logic m, logic s, logic pv, logic [7:0] d,
                                logic r0, logic r1, logic e_rdy, logic e_cs,
                                logic e_v0, logic [7:0] e_d0,
                                logic e_v1, logic [7:0] e_d1);
      vec_t v;
      v.m = m; v.s = s; v.pv = pv; v.d = d; v.r0 = r0; v.r1 = r1;
      v.e_rdy = e_rdy; v.e_cs = e_cs; v.e_v0 = e_v0; v.e_d0 = e_d0;
      v.e_v1 = e_v1; v.e_d1 = e_d1;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic expect_out(input string tag, input logic e_rdy, input logic e_cs,
                             input logic e_v0, input logic [7:0] e_d0,
                             input logic e_v1, input logic [7:0] e_d1);
      check({tag, ".ready"},   64'(push.ready), 64'(e_rdy));
      check({tag, ".cur_sel"}, 64'(cur_sel),    64'(e_cs));
      check({tag, ".v0"},      64'(pop0.valid), 64'(e_v0));
      check({tag, ".v1"},      64'(pop1.valid), 64'(e_v1));
      if (e_v0) check({tag, ".d0"}, 64'(pop0.data), {56'h0, e_d0});
      if (e_v1) check({tag, ".d1"}, 64'(pop1.data), {56'h0, e_d1});
   endtask

   task automatic drive(input logic m, input logic s, input logic pv, input logic [7:0] d,
                        input logic r0, input logic r1);
      mode       = m;
      sel        = s;
      push.valid = pv;
      push.data  = {24'h0, d};
      push.strb  = 4'hF;
      pop0.ready = r0;
      pop1.ready = r1;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // Reference model for the random run: per-destination FIFOs of {strb,data}
   // and a count of burst-mode beats since the last clear.
   logic [35:0] q0[$];
   logic [35:0] q1[$];
   int unsigned beats;

   initial begin
      rst = 1'b1; clear = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Reset state, with a push offered that must not be accepted.
      #12;
      push.valid = 1'b1;
      #1;
      expect_out("reset", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("reset.data0", 64'(pop0.data), 64'h0);
      check("reset.data1", 64'(pop1.data), 64'h0);
      push.valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step();

      // Static routing
      tbl.push_back(mkv(0,1,1,8'hA0,1,1, 1,1, 0,8'h00, 0,8'h00));
      tbl.push_back(mkv(0,1,1,8'hA1,1,1, 1,1, 0,8'h00, 1,8'hA0));
      tbl.push_back(mkv(0,1,1,8'hA2,1,1, 1,1, 0,8'h00, 1,8'hA1));
      tbl.push_back(mkv(0,1,1,8'hA3,1,1, 1,1, 0,8'h00, 1,8'hA2));
      tbl.push_back(mkv(0,1,0,8'h00,1,1, 1,1, 0,8'h00, 1,8'hA3));
      tbl.push_back(mkv(0,1,0,8'h00,1,1, 1,1, 0,8'h00, 0,8'h00));
      // Burst alternation, BURST_LEN=4
      tbl.push_back(mkv(1,0,0,8'h00,1,1, 1,0, 0,8'h00, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h00,1,1, 1,0, 0,8'h00, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h01,1,1, 1,0, 1,8'h00, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h02,1,1, 1,0, 1,8'h01, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h03,1,1, 1,0, 1,8'h02, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h04,1,1, 1,1, 1,8'h03, 0,8'h00));
      tbl.push_back(mkv(1,0,1,8'h05,1,1, 1,1, 0,8'h00, 1,8'h04));
      tbl.push_back(mkv(1,0,1,8'h06,1,1, 1,1, 0,8'h00, 1,8'h05));
      tbl.push_back(mkv(1,0,1,8'h07,1,1, 1,1, 0,8'h00, 1,8'h06));
      tbl.push_back(mkv(1,0,1,8'h08,1,1, 1,0, 0,8'h00, 1,8'h07));
      tbl.push_back(mkv(1,0,1,8'h09,1,1, 1,0, 1,8'h08, 0,8'h00));
      tbl.push_back(mkv(1,0,0,8'h00,1,1, 1,0, 1,8'h09, 0,8'h00));
      // Backpressure on pop_0
      tbl.push_back(mkv(0,0,0,8'h00,0,1, 1,0, 0,8'h00, 0,8'h00));
      tbl.push_back(mkv(0,0,1,8'h11,0,1, 1,0, 0,8'h00, 0,8'h00));
      tbl.push_back(mkv(0,0,1,8'h22,0,1, 0,0, 1,8'h11, 0,8'h00));
      tbl.push_back(mkv(0,0,1,8'h22,0,1, 0,0, 1,8'h11, 0,8'h00));
      tbl.push_back(mkv(0,0,1,8'h22,1,1, 1,0, 1,8'h11, 0,8'h00));
      // Independent drain while pop_0 stays stalled
      tbl.push_back(mkv(0,1,1,8'h44,0,1, 1,1, 1,8'h22, 0,8'h00));
      tbl.push_back(mkv(0,1,0,8'h00,0,1, 1,1, 1,8'h22, 1,8'h44));
      tbl.push_back(mkv(0,1,0,8'h00,1,1, 1,1, 1,8'h22, 0,8'h00));
      tbl.push_back(mkv(0,1,0,8'h00,1,1, 1,1, 0,8'h00, 0,8'h00));

      foreach (tbl[i]) begin
         drive(tbl[i].m, tbl[i].s, tbl[i].pv, tbl[i].d, tbl[i].r0, tbl[i].r1);
         #2;
         expect_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_cs,
                    tbl[i].e_v0, tbl[i].e_d0, tbl[i].e_v1, tbl[i].e_d1);
         step();
      end

      // Clear with both registers full; burst position is cnt=2, sel=0 here.
      drive(1, 0, 0, 8'h00, 1, 1); step();
      drive(1, 0, 1, 8'h60, 1, 0); #2; expect_out("clr.p60", 1, 0, 0, 8'h00, 0, 8'h00); step();
      drive(1, 0, 1, 8'h61, 1, 0); #2; expect_out("clr.p61", 1, 0, 1, 8'h60, 0, 8'h00); step();
      drive(1, 0, 1, 8'h62, 0, 0); #2; expect_out("clr.p62", 1, 1, 1, 8'h61, 0, 8'h00); step();
      drive(1, 0, 1, 8'h70, 0, 0); clear = 1'b1; #2;
      expect_out("clr.cyc", 0, 1, 1, 8'h61, 1, 8'h62);
      step();
      clear = 1'b0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 1, 8'h80 + 8'(i), 1, 1);
         #2;
         if (i == 0) expect_out("clr.b0", 1, 0, 0, 8'h00, 0, 8'h00);
         else if (i < 4) expect_out($sformatf("clr.b%0d", i), 1, 0, 1, 8'h80 + 8'(i - 1), 0, 8'h00);
         else expect_out("clr.b4", 1, 1, 1, 8'h83, 0, 8'h00);
         step();
      end
      drive(1, 0, 0, 8'h00, 1, 1); #2; expect_out("clr.tail", 1, 1, 0, 8'h00, 1, 8'h84); step();

      // Async reset with both registers holding beats (cnt=1, sel=1 now).
      drive(1, 0, 1, 8'h90, 0, 0); step();
      drive(0, 0, 0, 8'h00, 0, 0); step();
      drive(0, 0, 1, 8'h91, 0, 0); step();
      drive(1, 0, 0, 8'h00, 0, 0); #1;
      expect_out("prerst", 1'b0, 1'b1, 1'b1, 8'h91, 1'b1, 8'h90);
      #1; rst = 1'b1; #1;
      expect_out("rst.mid", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      check("rst.data0", 64'(pop0.data), 64'h0);
      check("rst.data1", 64'(pop1.data), 64'h0);
      push.valid = 1'b1; push.data = 32'hBB;
      step();
      check("rst.noacc", 64'(pop0.valid), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 1, 8'hA5, 1, 1);
      #1;
      expect_out("rst.rel", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      step();
      push.valid = 1'b0;
      #1;
      expect_out("rst.first", 1'b1, 1'b0, 1'b1, 8'hA5, 1'b0, 8'h00);
      step();

      // Randomized run; starts from a clear so the model is in sync.
      clear = 1'b1; drive(0, 0, 0, 8'h00, 1, 1); step();
      clear = 1'b0;
      q0.delete(); q1.delete(); beats = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         logic pv, r0, r1, clr, d, rdy;
         logic [31:0] dat;
         logic [3:0]  stb;
         pv  = ($urandom_range(0, 2) != 0);
         if (!pv && ($urandom_range(0, 7) == 0)) mode = !mode;
         sel = 1'($urandom_range(0, 1));
         r0  = ($urandom_range(0, 3) != 0);
         r1  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 63) == 0);
         dat = $urandom;
         stb = 4'($urandom);
         push.valid = pv; push.data = dat; push.strb = stb;
         pop0.ready = r0; pop1.ready = r1; clear = clr;
         #2;
         d   = mode ? 1'((beats / BL) % 2) : sel;
         rdy = !clr && (d ? (q1.size() == 0 || r1) : (q0.size() == 0 || r0));
         check("rnd.cur_sel", 64'(cur_sel), 64'(d));
         check("rnd.ready", 64'(push.ready), 64'(rdy));
         check("rnd.v0", 64'(pop0.valid), 64'(q0.size() != 0));
         check("rnd.v1", 64'(pop1.valid), 64'(q1.size() != 0));
         if (q0.size() != 0) check("rnd.beat0", 64'({pop0.strb, pop0.data}), 64'(q0[0]));
         if (q1.size() != 0) check("rnd.beat1", 64'({pop1.strb, pop1.data}), 64'(q1[0]));
         if (clr) begin
            q0.delete(); q1.delete(); beats = 0;
         end else begin
            if (r0 && q0.size() != 0) void'(q0.pop_front());
            if (r1 && q1.size() != 0) void'(q1.pop_front());
            if (pv && rdy) begin
               if (d) q1.push_back({stb, dat});
               else   q0.push_back({stb, dat});
               if (mode) beats++;
            end
         end
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
